// File: rtl/fetch_unit.sv
// fetch_unit -- instruction fetch front end between the PC register, the
// instruction memory and decode.
//
// Ports:
//   clk            sole clock; all state updates on the rising edge
//   reset          asynchronous, active-low reset
//   PC             current fetch address from the external PC register
//   pc_en          advance the PC register (high on an accepted request)
//   redirect       branch/jump flush; the PC register reloads externally
//   imem_req_*     request channel to instruction memory (valid/ready/addr)
//   imem_rsp_*     in-order response channel (one response per request)
//   if_*           instruction channel to decode (valid/ready/instr/pc)
//   if_fault       misaligned-fetch flag (only with FETCH_ALIGN_CHECK_EN)
//
// Optional feature: define FETCH_ALIGN_CHECK_EN to capture a misalignment
// flag (PC[1:0] != 0) at request time and deliver it on if_fault.
//
// Requests are issued only while outstanding + buffered < 2, so the 2-entry
// output FIFO can never overflow. After a redirect, responses still in
// flight are discarded by counting them off with the drop counter.
module fetch_unit #(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [XLEN-1:0] PC,
   output logic            pc_en,
   input  logic            redirect,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [XLEN-1:0] imem_rsp_data,
   output logic            if_valid,
   input  logic            if_ready,
   output logic [XLEN-1:0] if_instr,
   output logic [XLEN-1:0] if_pc
`ifdef FETCH_ALIGN_CHECK_EN
   ,
   output logic            if_fault
`endif
);

   // address queue: PC of each outstanding request, in issue order
   logic [XLEN-1:0] aq_pc [2];
   logic            aq_wr, aq_rd;

   // output FIFO toward decode
   logic [XLEN-1:0] fq_pc    [2];
   logic [XLEN-1:0] fq_instr [2];
   logic            fq_wr, fq_rd;
   logic [1:0]      fq_cnt;

   logic [1:0]      outstanding;
   logic [1:0]      drop;

`ifdef FETCH_ALIGN_CHECK_EN
   logic            aq_fault [2];
   logic            fq_fault [2];
`endif

   logic [2:0]      inflight;
   logic            req_fire;
   logic            rsp_take;
   logic            rsp_keep;
   logic            fq_pop;

   always_comb begin
      inflight       = {1'b0, outstanding} + {1'b0, fq_cnt};
      imem_req_valid = reset && !redirect && (inflight < 3'd2);
      imem_req_addr  = PC;
      req_fire       = imem_req_valid && imem_req_ready;
      pc_en          = req_fire;
      // a response with nothing outstanding is stray and ignored entirely
      rsp_take       = imem_rsp_valid && (outstanding != 2'd0);
      // the response arriving in a redirect cycle is stale as well
      rsp_keep       = rsp_take && !redirect && (drop == 2'd0);
      if_valid       = (fq_cnt != 2'd0);
      fq_pop         = if_valid && if_ready && !redirect;
      if_pc          = if_valid ? fq_pc[fq_rd]    : '0;
      if_instr       = if_valid ? fq_instr[fq_rd] : '0;
`ifdef FETCH_ALIGN_CHECK_EN
      if_fault       = if_valid ? fq_fault[fq_rd] : 1'b0;
`endif
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         aq_pc       <= '{default: '0};
         aq_wr       <= 1'b0;
         aq_rd       <= 1'b0;
         outstanding <= '0;
         drop        <= '0;
`ifdef FETCH_ALIGN_CHECK_EN
         aq_fault    <= '{default: 1'b0};
`endif
      end else begin
         if (req_fire) begin
            aq_pc[aq_wr] <= PC;
`ifdef FETCH_ALIGN_CHECK_EN
            aq_fault[aq_wr] <= (PC[1:0] != 2'b00);
`endif
            aq_wr <= ~aq_wr;
         end
         if (rsp_take)
            aq_rd <= ~aq_rd;
         outstanding <= outstanding + {1'b0, req_fire} - {1'b0, rsp_take};
         // no request can fire during redirect, so every request still
         // outstanding after this cycle's response is stale
         if (redirect)
            drop <= outstanding - {1'b0, rsp_take};
         else if (rsp_take && (drop != 2'd0))
            drop <= drop - 2'd1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fq_pc    <= '{default: '0};
         fq_instr <= '{default: '0};
         fq_wr    <= 1'b0;
         fq_rd    <= 1'b0;
         fq_cnt   <= '0;
`ifdef FETCH_ALIGN_CHECK_EN
         fq_fault <= '{default: 1'b0};
`endif
      end else if (redirect) begin
         fq_wr  <= 1'b0;
         fq_rd  <= 1'b0;
         fq_cnt <= '0;
      end else begin
         if (rsp_keep) begin
            fq_pc[fq_wr]    <= aq_pc[aq_rd];
            fq_instr[fq_wr] <= imem_rsp_data;
`ifdef FETCH_ALIGN_CHECK_EN
            fq_fault[fq_wr] <= aq_fault[aq_rd];
`endif
            fq_wr <= ~fq_wr;
         end
         if (fq_pop)
            fq_rd <= ~fq_rd;
         fq_cnt <= fq_cnt + {1'b0, rsp_keep} - {1'b0, fq_pop};
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit -- self-checking bench for fetch_unit: a cycle table for the
// streaming case, then a memory/PC model with an expected-output queue for
// backpressure, redirects, reset and random traffic.
module tb_fetch_unit;

   logic        clk;
   logic        reset;
   logic [31:0] PC;
   logic        pc_en;
   logic        redirect;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
`ifdef FETCH_ALIGN_CHECK_EN
   logic        if_fault;
`endif

   fetch_unit #(.XLEN(32)) dut (
      .clk            (clk),
      .reset          (reset),
      .PC             (PC),
      .pc_en          (pc_en),
      .redirect       (redirect),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .if_valid       (if_valid),
      .if_ready       (if_ready),
      .if_instr       (if_instr),
      .if_pc          (if_pc)
`ifdef FETCH_ALIGN_CHECK_EN
      ,
      .if_fault       (if_fault)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned checks = 0;
   int unsigned errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   // streaming table: one row per cycle
   typedef struct {
      logic [31:0] pc;
      logic        rdy;
      logic        rsp;
      logic [31:0] data;
      logic        ifr;
      logic        e_pcen;
      logic        e_rv;
      logic        e_ifv;
      logic [31:0] e_ifpc;
      logic [31:0] e_instr;
   } vec_t;

   vec_t tbl [7];

   function automatic vec_t mkv(input logic [31:0] pc, input logic rdy, input logic rsp,
                                input logic [31:0] data, input logic ifr, input logic e_pcen,
                                input logic e_rv, input logic e_ifv, input logic [31:0] e_ifpc,
                                input logic [31:0] e_instr);
      vec_t v;
      v.pc = pc; v.rdy = rdy; v.rsp = rsp; v.data = data; v.ifr = ifr;
      v.e_pcen = e_pcen; v.e_rv = e_rv; v.e_ifv = e_ifv;
      v.e_ifpc = e_ifpc; v.e_instr = e_instr;
      return v;
   endfunction

   // memory / scoreboard model
   typedef struct {
      logic [31:0] addr;
      bit          stale;
      int unsigned due;
   } pend_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      bit          fault;
   } exp_t;

   pend_t       pend  [$];
   exp_t        exp_q [$];
   logic [31:0] pc_model;
   int unsigned cyc_n = 0;
   int unsigned lat_min = 1;
   int unsigned lat_max = 1;
   int unsigned fires = 0;
   logic [31:0] first_addr;
   logic [31:0] last_pop_pc;

   function automatic logic [31:0] data_of(input logic [31:0] a);
      return 32'hDEAD_0000 + (a >> 2) + 32'd1;
   endfunction

   // one cycle, entered and left at a falling edge
   task automatic cyc(input logic red, input logic [31:0] tgt, input logic rdy, input logic ifr);
      bit    exp_rv;
      bit    rsp;
      pend_t p;
      exp_t  e;
      chk1("if_valid", if_valid, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
         chk("if_pc", if_pc, exp_q[0].pc);
         chk("if_instr", if_instr, exp_q[0].instr);
`ifdef FETCH_ALIGN_CHECK_EN
         chk1("if_fault", if_fault, exp_q[0].fault);
`endif
      end
      exp_rv = !red && ((pend.size() + exp_q.size()) < 2);
      rsp    = (pend.size() != 0) && (cyc_n >= pend[0].due);
      redirect       = red;
      imem_req_ready = rdy;
      if_ready       = ifr;
      PC             = pc_model;
      imem_rsp_valid = rsp;
      imem_rsp_data  = rsp ? data_of(pend[0].addr) : 32'hBAD0_BAD0;
      #1;
      chk1("imem_req_valid", imem_req_valid, exp_rv);
      chk1("pc_en", pc_en, exp_rv && rdy);
      if (exp_rv) chk("imem_req_addr", imem_req_addr, pc_model);
      if (pc_en) begin
         if (fires == 0) first_addr = imem_req_addr;
         fires++;
      end
      if (red) begin
         foreach (pend[i]) pend[i].stale = 1'b1;
         exp_q.delete();
      end else if (ifr && exp_q.size() != 0) begin
         last_pop_pc = if_pc;
         void'(exp_q.pop_front());
      end
      if (rsp) begin
         p = pend.pop_front();
         if (!p.stale && !red) begin
            e.pc = p.addr; e.instr = data_of(p.addr); e.fault = (p.addr[1:0] != 2'b00);
            exp_q.push_back(e);
         end
      end
      if (exp_rv && rdy) begin
         p.addr = pc_model; p.stale = 1'b0;
         p.due  = cyc_n + $urandom_range(lat_max, lat_min);
         pend.push_back(p);
         pc_model = pc_model + 32'd4;
      end
      if (red) pc_model = tgt;
      @(negedge clk);
      cyc_n++;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      reset = 1'b0; PC = '0; redirect = 1'b0; imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0; imem_rsp_data = '0; if_ready = 1'b0;
      first_addr = '0; last_pop_pc = '0; pc_model = '0;

      tbl[0] = mkv(32'h0, 1, 0, 32'h0,         1, 1, 1, 0, 32'h0, 32'h0);
      tbl[1] = mkv(32'h4, 1, 1, 32'h1000_0000, 1, 1, 1, 0, 32'h0, 32'h0);
      tbl[2] = mkv(32'h8, 1, 1, 32'h1000_0004, 1, 0, 0, 1, 32'h0, 32'h1000_0000);
      tbl[3] = mkv(32'h8, 1, 0, 32'h0,         1, 1, 1, 1, 32'h4, 32'h1000_0004);
      tbl[4] = mkv(32'hC, 0, 1, 32'h1000_0008, 1, 0, 1, 0, 32'h0, 32'h0);
      tbl[5] = mkv(32'hC, 0, 0, 32'h0,         1, 0, 1, 1, 32'h8, 32'h1000_0008);
      tbl[6] = mkv(32'hC, 0, 0, 32'h0,         1, 0, 1, 0, 32'h0, 32'h0);

      // reset state
      repeat (2) @(negedge clk);
      imem_req_ready = 1'b1;
      #1;
      chk1("rst if_valid", if_valid, 1'b0);
      chk1("rst imem_req_valid", imem_req_valid, 1'b0);
      chk1("rst pc_en", pc_en, 1'b0);
      chk("rst if_pc", if_pc, 32'h0);
      chk("rst if_instr", if_instr, 32'h0);
`ifdef FETCH_ALIGN_CHECK_EN
      chk1("rst if_fault", if_fault, 1'b0);
`endif
      imem_req_ready = 1'b0;
      reset = 1'b1;
      @(negedge clk);

      // streaming table
      for (int i = 0; i < 7; i++) begin
         chk1($sformatf("tbl%0d if_valid", i), if_valid, tbl[i].e_ifv);
         if (tbl[i].e_ifv) begin
            chk($sformatf("tbl%0d if_pc", i), if_pc, tbl[i].e_ifpc);
            chk($sformatf("tbl%0d if_instr", i), if_instr, tbl[i].e_instr);
         end
         PC = tbl[i].pc; imem_req_ready = tbl[i].rdy; imem_rsp_valid = tbl[i].rsp;
         imem_rsp_data = tbl[i].data; if_ready = tbl[i].ifr; redirect = 1'b0;
         #1;
         chk1($sformatf("tbl%0d pc_en", i), pc_en, tbl[i].e_pcen);
         chk1($sformatf("tbl%0d imem_req_valid", i), imem_req_valid, tbl[i].e_rv);
         @(negedge clk);
      end

      // backpressure: decode stalls for 5 cycles
      pc_model = 32'h40; lat_min = 1; lat_max = 1; fires = 0;
      repeat (5) cyc(1'b0, 32'h0, 1'b1, 1'b0);
      chk("bp accepted requests", fires, 32'd2);
      repeat (6) cyc(1'b0, 32'h0, 1'b1, 1'b1);

      // redirect with two requests outstanding
      repeat (3) cyc(1'b0, 32'h0, 1'b0, 1'b1);
      pc_model = 32'h0; lat_min = 3; lat_max = 3;
      repeat (2) cyc(1'b0, 32'h0, 1'b1, 1'b1);
      cyc(1'b1, 32'h100, 1'b1, 1'b1);
      fires = 0;
      repeat (8) cyc(1'b0, 32'h0, 1'b1, 1'b1);
      chk("redir first addr", first_addr, 32'h100);

      // back-to-back redirects
      repeat (6) cyc(1'b0, 32'h0, 1'b0, 1'b1);
      pc_model = 32'h400;
      repeat (2) cyc(1'b0, 32'h0, 1'b1, 1'b1);
      cyc(1'b1, 32'h500, 1'b1, 1'b1);
      cyc(1'b1, 32'h600, 1'b1, 1'b1);
      fires = 0;
      repeat (10) cyc(1'b0, 32'h0, 1'b1, 1'b1);
      chk("b2b first addr", first_addr, 32'h600);

      // redirect coincident with a response
      repeat (6) cyc(1'b0, 32'h0, 1'b0, 1'b1);
      pc_model = 32'h200; lat_min = 2; lat_max = 2;
      repeat (2) cyc(1'b0, 32'h0, 1'b1, 1'b1);
      cyc(1'b1, 32'h300, 1'b0, 1'b1);
      fires = 0;
      cyc(1'b0, 32'h0, 1'b1, 1'b1);
      repeat (6) cyc(1'b0, 32'h0, 1'b0, 1'b1);
      chk("coinc first addr", first_addr, 32'h300);
      chk("coinc delivered pc", last_pop_pc, 32'h300);

`ifdef FETCH_ALIGN_CHECK_EN
      // misaligned then aligned fetch
      cyc(1'b1, 32'h6, 1'b0, 1'b1);
      cyc(1'b0, 32'h0, 1'b1, 1'b1);
      cyc(1'b1, 32'h8, 1'b0, 1'b1);
      cyc(1'b0, 32'h0, 1'b1, 1'b1);
      repeat (6) cyc(1'b0, 32'h0, 1'b0, 1'b1);
`endif

      // random traffic
      lat_min = 1; lat_max = 3;
      for (int i = 0; i < 300; i++) begin
         logic [31:0] tgt;
         tgt = $urandom & 32'h0000_0FFC;
`ifdef FETCH_ALIGN_CHECK_EN
         tgt = tgt | $urandom_range(0, 3);
`endif
         cyc($urandom_range(0, 15) == 0, tgt, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
      end
      repeat (8) cyc(1'b0, 32'h0, 1'b0, 1'b1);

      // reset mid-operation with two outstanding
      pc_model = 32'h800; lat_min = 3; lat_max = 3;
      repeat (2) cyc(1'b0, 32'h0, 1'b1, 1'b1);
      reset = 1'b0; imem_req_ready = 1'b1; if_ready = 1'b1;
      #1;
      chk1("midrst imem_req_valid", imem_req_valid, 1'b0);
      chk1("midrst pc_en", pc_en, 1'b0);
      chk1("midrst if_valid", if_valid, 1'b0);
      pend.delete(); exp_q.delete();
      @(negedge clk);
      chk("midrst if_pc", if_pc, 32'h0);
      chk("midrst if_instr", if_instr, 32'h0);
      imem_req_ready = 1'b0; reset = 1'b1;
      imem_rsp_valid = 1'b1; imem_rsp_data = 32'h5555_AAAA;
      @(negedge clk);
      chk1("stray rsp if_valid", if_valid, 1'b0);
      imem_rsp_valid = 1'b1;
      @(negedge clk);
      chk1("stray rsp2 if_valid", if_valid, 1'b0);
      pc_model = 32'h900; lat_min = 1; lat_max = 1; fires = 0;
      repeat (8) cyc(1'b0, 32'h0, 1'b1, 1'b1);
      chk("post rst first addr", first_addr, 32'h900);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
